// File: rtl/memory_pkg.sv
// memory_pkg: shared definitions for the memory front end.
//   state_t       - front-end FSM states
//   F3_*          - RV32I load/store width codes carried on funct3
//   access_fault  - classifies a request as illegal (bad width code or
//                   misaligned) from its direction, width code and the
//                   two low address bits
package memory_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic access_fault(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic bad_code;
    logic misaligned;
    // Stores have no unsigned variants, so only B/H/W are legal for them.
    if (write)
      bad_code = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      bad_code = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && offset[0]) ||
                 ((funct3 == F3_W) && (offset != 2'b00));
    return bad_code || misaligned;
  endfunction

endpackage

// File: rtl/byte_lane_aligner.sv
// byte_lane_aligner: combinational lane logic between the core and a
// word-wide backend.
//   funct3      in  width code of the access
//   offset      in  address[1:0] of the access
//   read_word   in  word read from the backend
//   store_data  in  store source; byte/half taken from the low bits
//   load_value  out selected lane, sign- or zero-extended to 32 bits
//   merged_word out read_word with the addressed byte/half replaced by
//                   store_data (store_data itself for other codes)
module byte_lane_aligner
  import memory_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] read_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;
  logic signed [31:0] byte_sext;
  logic signed [31:0] half_sext;

  always_comb begin
    byte_lane = 8'(read_word >> {offset, 3'b000});
    half_lane = 16'(read_word >> {offset[1], 4'b0000});
    // Signed-to-signed widening assignment replicates the lane's top bit.
    byte_sext = byte_lane;
    half_sext = half_lane;

    case (funct3)
      F3_B:    load_value = byte_sext;
      F3_H:    load_value = half_sext;
      F3_BU:   load_value = {24'd0, byte_lane};
      F3_HU:   load_value = {16'd0, half_lane};
      default: load_value = read_word;
    endcase
  end

  always_comb begin
    merged_word = read_word;
    case (funct3)
      F3_B:    merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
      F3_H:    merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/memory_frontend.sv
// memory_frontend: RV32I load/store front end for a 1-cycle synchronous RAM.
//   clock, reset          clock; asynchronous active-low reset
//   reqValid/reqReady     request handshake (ready only in IDLE)
//   reqWrite, funct3      direction and width code of the request
//   address, storeData    byte address and store source
//   respValid             one-cycle completion pulse
//   loadData, accessFault result and fault flag, held until next accept
//   backendAddress        word address (latched address[31:2])
//   backendDataOut        backend read data, 1 cycle after the address
//   backendDataIn         backend write data
//   backendWriteEnable    backend write strobe
// Sub-word stores are read-modify-write: READ presents the address, DATA
// merges the new lane into the returned word and writes it back.
module memory_frontend
  import memory_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        respValid,
  output logic [31:0] loadData,
  output logic        accessFault,
  output logic [29:0] backendAddress,
  input  logic [31:0] backendDataOut,
  output logic [31:0] backendDataIn,
  output logic        backendWriteEnable
);

  state_t      state;
  state_t      next_state;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store;
  logic        accept;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  assign accept = (state == IDLE) && reqValid;

  byte_lane_aligner u_aligner (
    .funct3      (req_funct3),
    .offset      (req_address[1:0]),
    .read_word   (backendDataOut),
    .store_data  (req_store),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Request registers and result registers; results clear on every accept
  // so stores and faults report loadData=0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_write   <= 1'b0;
      req_funct3  <= 3'd0;
      req_address <= 32'd0;
      req_store   <= 32'd0;
      loadData    <= 32'd0;
      accessFault <= 1'b0;
    end else if (accept) begin
      req_write   <= reqWrite;
      req_funct3  <= funct3;
      req_address <= address;
      req_store   <= storeData;
      loadData    <= 32'd0;
      accessFault <= access_fault(reqWrite, funct3, address[1:0]);
    end else if (state == DATA && !req_write) begin
      loadData    <= load_value;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (reqValid) begin
          if (access_fault(reqWrite, funct3, address[1:0])) next_state = RESP;
          else if (reqWrite && funct3 == F3_W)               next_state = WRITE;
          else                                               next_state = READ;
        end
      end
      READ:    next_state = DATA;
      DATA:    next_state = RESP;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    reqReady           = (state == IDLE);
    respValid          = (state == RESP);
    backendAddress     = req_address[31:2];
    backendWriteEnable = (state == WRITE) || (state == DATA && req_write);
    backendDataIn      = (state == WRITE) ? req_store : merged_word;
  end

endmodule

// File: tb/tb_memory_frontend.sv
// Testbench for memory_frontend: a 16-word synchronous RAM behind the
// backend port, and a word-array reference model of memory contents used
// to predict load results, fault flags, latencies and write traffic.
module tb_memory_frontend;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] storeData = 32'd0;
  logic        respValid;
  logic [31:0] loadData;
  logic        accessFault;
  logic [29:0] backendAddress;
  logic [31:0] backendDataOut;
  logic [31:0] backendDataIn;
  logic        backendWriteEnable;

  memory_frontend dut (
    .clock              (clock),
    .reset              (reset),
    .reqValid           (reqValid),
    .reqReady           (reqReady),
    .reqWrite           (reqWrite),
    .funct3             (funct3),
    .address            (address),
    .storeData          (storeData),
    .respValid          (respValid),
    .loadData           (loadData),
    .accessFault        (accessFault),
    .backendAddress     (backendAddress),
    .backendDataOut     (backendDataOut),
    .backendDataIn      (backendDataIn),
    .backendWriteEnable (backendWriteEnable)
  );

  always #5 clock = ~clock;

  // Backend RAM with 1-cycle read latency.
  logic [31:0] ram [16];
  logic [31:0] rd_word;
  int          wr_count;
  logic [29:0] last_waddr;
  logic [31:0] last_wdata;

  always @(posedge clock) begin
    rd_word <= ram[backendAddress[3:0]];
    if (backendWriteEnable) begin
      ram[backendAddress[3:0]] <= backendDataIn;
      wr_count   <= wr_count + 1;
      last_waddr <= backendAddress;
      last_wdata <= backendDataIn;
    end
  end
  assign backendDataOut = rd_word;

  int          checks;
  int          errors;
  logic [31:0] ref_mem [16];
  logic [31:0] prev_load;
  logic        prev_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input bit w, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int size;
    if (w) legal = (f3 <= 3'd2);
    else   legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned word;
    int unsigned v;
    word = ref_mem[a[5:2]];
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * a[1:0])) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * a[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] sd);
    int unsigned word;
    int unsigned mask;
    int unsigned sh;
    word = ref_mem[a[5:2]];
    if (f3 == 3'd2) return sd;
    sh   = (f3 == 3'd0) ? 8 * a[1:0] : 16 * a[1];
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (word & ~mask) | ((sd << sh) & mask);
  endfunction

  // One transaction: drive in IDLE, wait (bounded) for the response, compare
  // latency, result, fault flag and backend write traffic with the model.
  task automatic run_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input bit keep, input string tag);
    bit          exp_fault;
    logic [31:0] exp_load;
    logic [31:0] exp_word;
    int          exp_lat;
    int          exp_writes;
    int          lat;
    int          w0;
    bit          seen;
    exp_fault  = model_fault(w, f3, a);
    exp_load   = (exp_fault || w) ? 32'd0 : model_load(f3, a);
    exp_word   = model_store(f3, a, sd);
    exp_lat    = exp_fault ? 1 : (w && f3 == 3'd2) ? 2 : 3;
    exp_writes = (w && !exp_fault) ? 1 : 0;

    @(negedge clock);
    check({tag, "/ready_idle"}, {31'd0, reqReady}, 32'd1);
    check({tag, "/resp_low"}, {31'd0, respValid}, 32'd0);
    check({tag, "/load_hold"}, loadData, prev_load);
    check({tag, "/fault_hold"}, {31'd0, accessFault}, {31'd0, prev_fault});
    reqValid  = 1'b1;
    reqWrite  = w;
    funct3    = f3;
    address   = a;
    storeData = sd;
    w0 = wr_count;
    @(posedge clock);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 6 && !seen; k++) begin
      @(negedge clock);
      if (!keep) reqValid = 1'b0;
      check({tag, "/ready_busy"}, {31'd0, reqReady}, 32'd0);
      if (respValid === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/fault"}, {31'd0, accessFault}, {31'd0, exp_fault});
    check({tag, "/loadData"}, loadData, exp_load);
    check({tag, "/writes"}, wr_count - w0, exp_writes);
    if (exp_writes == 1) begin
      check({tag, "/waddr"}, {2'b00, last_waddr}, {2'b00, a[31:2]});
      check({tag, "/wdata"}, last_wdata, exp_word);
      ref_mem[a[5:2]] = exp_word;
    end
    prev_load  = exp_load;
    prev_fault = exp_fault;
  endtask

  initial begin
    bit          w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] v;
    int          w0;
    bit          any_we;
    bit          any_resp;
    checks = 0;
    errors = 0;
    prev_load  = 32'd0;
    prev_fault = 1'b0;

    // Reset state
    #1;
    check("rst/ready", {31'd0, reqReady}, 32'd1);
    check("rst/resp", {31'd0, respValid}, 32'd0);
    check("rst/we", {31'd0, backendWriteEnable}, 32'd0);
    check("rst/fault", {31'd0, accessFault}, 32'd0);
    check("rst/load", loadData, 32'd0);
    check("rst/baddr", {2'b00, backendAddress}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Fill memory with word stores
    for (int i = 0; i < 16; i++) begin
      v = (i == 0) ? 32'h80FF_1234 : (i == 4) ? 32'h1122_3344 : $urandom;
      run_req(1'b1, 3'd2, i * 4, v, 1'b0, "fill");
    end

    // Sign/zero-extended byte loads
    run_req(1'b0, 3'd0, 32'h3, 32'd0, 1'b0, "lb3");
    check("lb3/const", loadData, 32'hFFFF_FF80);
    run_req(1'b0, 3'd4, 32'h3, 32'd0, 1'b0, "lbu3");
    check("lbu3/const", loadData, 32'h0000_0080);

    // Halfword read-modify-write then word readback
    run_req(1'b1, 3'd1, 32'h12, 32'hAAAA_BEEF, 1'b0, "sh12");
    check("sh12/const", last_wdata, 32'hBEEF_3344);
    run_req(1'b0, 3'd2, 32'h10, 32'd0, 1'b0, "lw10");
    check("lw10/const", loadData, 32'hBEEF_3344);

    // Word store, then faulting requests
    run_req(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, 1'b0, "sw8");
    run_req(1'b0, 3'd2, 32'h6, 32'd0, 1'b0, "lw6_mis");
    run_req(1'b0, 3'd3, 32'h4, 32'd0, 1'b0, "ld_f3_011");
    run_req(1'b1, 3'd4, 32'h4, 32'h1234_5678, 1'b0, "st_f3_100");

    // Back-to-back loads with reqValid held high
    for (int i = 0; i < 4; i++)
      run_req(1'b0, 3'($urandom_range(0, 2)), 32'(i * 8), 32'd0, i != 3, "b2b");

    // Reset pulsed in the DATA cycle of a byte store
    @(negedge clock);
    reqValid  = 1'b1;
    reqWrite  = 1'b1;
    funct3    = 3'd0;
    address   = 32'h21;
    storeData = 32'h0000_0055;
    w0 = wr_count;
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("rstmid/we", {31'd0, backendWriteEnable}, 32'd0);
    check("rstmid/ready", {31'd0, reqReady}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    any_we   = 1'b0;
    any_resp = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      any_we   |= backendWriteEnable;
      any_resp |= respValid;
    end
    check("rstmid/no_we", {31'd0, any_we}, 32'd0);
    check("rstmid/no_resp", {31'd0, any_resp}, 32'd0);
    check("rstmid/writes", wr_count - w0, 32'd0);
    check("rstmid/ready_after", {31'd0, reqReady}, 32'd1);
    prev_load  = 32'd0;
    prev_fault = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 63));
      run_req(w, f3, a, $urandom, 1'($urandom_range(0, 1)) && (i != 59), "rand");
    end

    // Final readback of every word
    for (int i = 0; i < 16; i++)
      run_req(1'b0, 3'd2, i * 4, 32'd0, 1'b0, "readback");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_frontend.md
MEMORY_FRONTEND -- requirements
Module: memory_frontend

Interface
REQ-001 The block SHALL have no parameters; the backend read latency is fixed at 1 cycle (synchronous RAM).
REQ-002 The block SHALL have these ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low
reqValid  in  1  load/store request present
reqReady  out  1  block can accept a request this cycle
reqWrite  in  1  1 = store, 0 = load
funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
address  in  32  byte address
storeData  in  32  store source; byte/half taken from low bits
respValid  out  1  one-cycle completion pulse
loadData  out  32  extended load result, valid while respValid=1
accessFault  out  1  qualifies respValid: misaligned or illegal funct3
backendAddress  out  30  word address to backend
backendDataOut  in  32  backend read data, valid 1 cycle after address
backendDataIn  out  32  word to write to backend
backendWriteEnable  out  1  backend write strobe

Function
REQ-003 States SHALL be IDLE, READ, DATA, WRITE, RESP.
REQ-004 reqReady SHALL be 1 exactly when state is IDLE (combinational).
REQ-005 Accept SHALL occur on an edge with reqValid=1 in IDLE; reqWrite, funct3, address and storeData are latched.
REQ-006 Fault cases: loads with funct3 in {011,110,111}; stores with funct3 not in {000,001,010}; H/HU with address[0]=1; W with address[1:0]!=00.
REQ-007 On a fault, IDLE SHALL go to RESP with accessFault=1 and loadData=0, and no backend write occurs.
REQ-008 For SW with no fault, IDLE SHALL go to WRITE.
REQ-009 For loads and SB/SH with no fault, IDLE SHALL go to READ.
REQ-010 READ SHALL last one cycle and then go to DATA.
REQ-011 In DATA for a load, the selected lane SHALL be sign-extended (B/H) or zero-extended (BU/HU/W) and registered into loadData; the next state is RESP.
REQ-012 In DATA for SB/SH, backendDataIn SHALL be backendDataOut with the addressed byte lane (address[1:0]) or halfword lane (address[1]) replaced; backendWriteEnable=1; the next state is RESP.
REQ-013 In WRITE, backendDataIn SHALL equal storeData and backendWriteEnable=1; the next state is RESP.
REQ-014 backendAddress SHALL equal latched address[31:2] in all states.
REQ-015 backendWriteEnable SHALL be 0 in every state except DATA(store) and WRITE.
REQ-016 RESP SHALL drive respValid=1 for exactly one cycle and then return to IDLE.
REQ-017 loadData and accessFault SHALL hold until the next accept.
REQ-018 Latency from the accept edge to respValid: load or SB/SH 3 cycles, SW 2 cycles, fault 1 cycle.
REQ-019 reqValid outside IDLE SHALL be ignored; the requester holds it until reqReady=1.
REQ-020 A new request SHALL be accepted no earlier than the cycle after RESP.
REQ-021 Stores SHALL produce loadData=0.

Reset
REQ-022 reset=0 SHALL immediately force state=IDLE, respValid=0, backendWriteEnable=0, accessFault=0, loadData=0 and the latched request registers to 0.
REQ-023 Reset asserted mid-operation (READ, DATA or WRITE) SHALL abandon the access with no backend write after assertion, and no response is issued.

Structure
REQ-024 Shared package memory_pkg SHALL hold the state enum and the funct3 width-code constants.
REQ-025 The lane extract/extend and lane merge logic SHALL be one combinational sub-module, byte_lane_aligner.
REQ-026 The remaining RTL (FSM and request registers) SHALL reside in memory_frontend.

Verification
REQ-027 LB at 0x0000_0003, memory word 0x80FF_1234 -> after 3 cycles respValid=1, loadData=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-028 SH storeData=0xAAAA_BEEF at 0x0000_0012, old word 0x1122_3344 -> one write of 0xBEEF_3344 to word 4; then LW 0x10 returns 0xBEEF_3344.
REQ-029 SW 0xDEAD_BEEF at 0x0000_0008 -> backendWriteEnable high exactly one cycle, respValid 2 cycles after accept, accessFault=0.
REQ-030 LW at 0x0000_0006 and load funct3=011 -> respValid 1 cycle after accept, accessFault=1, no backend write.
REQ-031 Reset pulsed while in DATA of an SB -> backendWriteEnable never asserts, state IDLE, reqReady=1, no respValid.
REQ-032 reqValid held high continuously with back-to-back requests -> each accepted only in IDLE; reqReady pattern 1,0,0,0,1 for loads.
